sdft_bin_reader: RTL

//  Master/controller for the sliding-DFT block: feeds ADC samples through its start/ready handshake,
//  and every SAMPLES_PER_LINE samples scans all bins via read/bin_addr, converts each complex bin
//  to an 8-bit magnitude and streams it as one waterfall display line (valid/ready) to the line buffer.

---
 rtl/sdft_bin_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sdft_bin_reader.sv
// sdft_bin_reader: feeds ADC samples into the sliding-DFT and scans its bins into waterfall pixels.
// Build option: define ALPHA_MAX_BETA_MIN_EN for max+min/2 magnitude instead of |re|+|im|.
//
// state     | meaning
// IDLE      | pick next SDFT job: buffered sample first, else next bin while scanning
// REQ_START | sdft_start pulse with sdft_sample
// REQ_READ  | sdft_read pulse with sdft_bin_addr
// WAIT_LOW  | wait for SDFT to go busy
// WAIT_HIGH | wait for SDFT to finish; bin data captured on exit of a read
// MAG       | register magnitude pixel
// PIX       | hold pixel until sink accepts
module sdft_bin_reader #(
  parameter int DATA_W           = 8,
  parameter int FREQ_BINS        = 320,
  parameter int FREQ_W           = 20,
  parameter int SAMPLES_PER_LINE = 64,
  parameter int MAG_SHIFT        = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_W-1:0]            sample_in,
  input  logic                         sample_valid,
  input  logic                         sdft_ready,
  input  logic signed [FREQ_W-1:0]     bin_real,
  input  logic signed [FREQ_W-1:0]     bin_imag,
  output logic                         sdft_start,
  output logic [DATA_W-1:0]            sdft_sample,
  output logic                         sdft_read,
  output logic [$clog2(FREQ_BINS)-1:0] sdft_bin_addr,
  output logic [7:0]                   pix_data,
  output logic [$clog2(FREQ_BINS)-1:0] pix_bin,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic                         line_done,
  output logic                         overrun
);

  localparam int BIN_W = $clog2(FREQ_BINS);
  localparam int CNT_W = $clog2(SAMPLES_PER_LINE + 1);
  localparam int MW    = FREQ_W + 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FREQ_BINS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE, REQ_START, REQ_READ, WAIT_LOW, WAIT_HIGH, MAG, PIX
  } state_t;

  state_t             state;
  logic               buf_full;
  logic [DATA_W-1:0]  buf_data;
  logic [CNT_W-1:0]   sample_cnt;
  logic               scanning;
  logic               line_pending;
  logic [BIN_W-1:0]   bin_idx;
  logic               txn_is_start;
  logic [FREQ_W-1:0]  re_q;
  logic [FREQ_W-1:0]  im_q;

  logic [MW-1:0] re_ext, im_ext, abs_re, abs_im, mag_raw, mag_shr;
  logic [7:0]    mag_pix;

  // Widened by one bit so the most negative component has an exact absolute value.
  always_comb begin
    re_ext = {re_q[FREQ_W-1], re_q};
    im_ext = {im_q[FREQ_W-1], im_q};
    abs_re = re_ext[MW-1] ? (~re_ext + MW'(1)) : re_ext;
    abs_im = im_ext[MW-1] ? (~im_ext + MW'(1)) : im_ext;
`ifdef ALPHA_MAX_BETA_MIN_EN
    mag_raw = (abs_re > abs_im) ? (abs_re + (abs_im >> 1)) : (abs_im + (abs_re >> 1));
`else
    mag_raw = abs_re + abs_im;
`endif
    mag_shr = mag_raw >> MAG_SHIFT;
    mag_pix = (mag_shr > MW'(255)) ? 8'hFF : mag_shr[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      buf_full      <= 1'b0;
      buf_data      <= '0;
      sample_cnt    <= '0;
      scanning      <= 1'b0;
      line_pending  <= 1'b0;
      bin_idx       <= '0;
      txn_is_start  <= 1'b0;
      re_q          <= '0;
      im_q          <= '0;
      sdft_start    <= 1'b0;
      sdft_sample   <= '0;
      sdft_read     <= 1'b0;
      sdft_bin_addr <= '0;
      pix_data      <= '0;
      pix_bin       <= '0;
      pix_valid     <= 1'b0;
      line_done     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      line_done <= 1'b0;

      // A strobe landing on the consume edge still sees the buffer full and is dropped.
      if (sample_valid) begin
        if (buf_full) begin
          overrun <= 1'b1;
        end else begin
          buf_full <= 1'b1;
          buf_data <= sample_in;
        end
      end

      case (state)
        IDLE: begin
          if (buf_full && sdft_ready) begin
            state        <= REQ_START;
            sdft_start   <= 1'b1;
            sdft_sample  <= buf_data;
            txn_is_start <= 1'b1;
          end else if (scanning && sdft_ready) begin
            state         <= REQ_READ;
            sdft_read     <= 1'b1;
            sdft_bin_addr <= bin_idx;
            txn_is_start  <= 1'b0;
          end
        end
        REQ_START, REQ_READ: begin
          sdft_start <= 1'b0;
          sdft_read  <= 1'b0;
          state      <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!sdft_ready) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (sdft_ready) begin
            if (txn_is_start) begin
              state    <= IDLE;
              buf_full <= 1'b0;
              if (sample_cnt == LAST_CNT) begin
                sample_cnt <= '0;
                // A line trigger during an active scan is deferred, never restarting it.
                if (scanning) begin
                  line_pending <= 1'b1;
                end else begin
                  scanning <= 1'b1;
                  bin_idx  <= '0;
                end
              end else begin
                sample_cnt <= sample_cnt + CNT_W'(1);
              end
            end else begin
              re_q  <= bin_real;
              im_q  <= bin_imag;
              state <= MAG;
            end
          end
        end
        MAG: begin
          pix_data  <= mag_pix;
          pix_bin   <= bin_idx;
          pix_valid <= 1'b1;
          state     <= PIX;
        end
        PIX: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            state     <= IDLE;
            if (bin_idx == LAST_BIN) begin
              line_done    <= 1'b1;
              bin_idx      <= '0;
              scanning     <= line_pending;
              line_pending <= 1'b0;
            end else begin
              bin_idx <= bin_idx + BIN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
